// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forward-select encodings, FSM state encoding and the control-output bundle.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic pipe_freeze;
    } hz_ctrl_t;

    function automatic hz_ctrl_t ctrl_run();
        hz_ctrl_t c;
        c.pc_write    = 1'b1;
        c.ifid_write  = 1'b1;
        c.ifid_flush  = 1'b0;
        c.idex_flush  = 1'b0;
        c.pipe_freeze = 1'b0;
        return c;
    endfunction

    // The EX/MEM producer is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_select(logic mem_hit, logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register observation and control bundle between the core and hazard_ctrl.
// master = controller side, slave = pipeline side.
interface hazard_ctrl_if #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 32
) ();

    logic [REG_IDX_W-1:0] idRs1;
    logic [REG_IDX_W-1:0] idRs2;
    logic                 idUsesRs1;
    logic                 idUsesRs2;
    logic [REG_IDX_W-1:0] exRs1;
    logic [REG_IDX_W-1:0] exRs2;
    logic [REG_IDX_W-1:0] exWriteAddr;
    logic                 exRegWrite;
    logic                 exMemRead;
    logic [REG_IDX_W-1:0] memWriteAddr;
    logic                 memRegWrite;
    logic [REG_IDX_W-1:0] wbWriteAddr;
    logic                 wbRegWrite;
    logic                 exPCSrc;
    logic                 memReq;
    logic                 memReady;

    logic                 PCWrite;
    logic                 IFIDWrite;
    logic                 IFIDFlush;
    logic                 IDEXFlush;
    logic                 pipeFreeze;
    logic [1:0]           forwardA;
    logic [1:0]           forwardB;
    logic [CNT_W-1:0]     stallCycles;
    logic [CNT_W-1:0]     flushCount;

    modport master (
        input  idRs1, idRs2, idUsesRs1, idUsesRs2,
        input  exRs1, exRs2, exWriteAddr, exRegWrite, exMemRead,
        input  memWriteAddr, memRegWrite, wbWriteAddr, wbRegWrite,
        input  exPCSrc, memReq, memReady,
        output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze,
        output forwardA, forwardB, stallCycles, flushCount
    );

    modport slave (
        output idRs1, idRs2, idUsesRs1, idUsesRs2,
        output exRs1, exRs2, exWriteAddr, exRegWrite, exMemRead,
        output memWriteAddr, memRegWrite, wbWriteAddr, wbRegWrite,
        output exPCSrc, memReq, memReady,
        input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, pipeFreeze,
        input  forwardA, forwardB, stallCycles, flushCount
    );

endinterface

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational ALU-operand forwarding select for one EX source register.
// Only compiled and used when HAZARD_FORWARD_EN is defined.
`ifdef HAZARD_FORWARD_EN
module hazard_ctrl_forward_unit
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] ex_rs_i,
    input  logic                 mem_reg_write_i,
    input  logic [REG_IDX_W-1:0] mem_write_addr_i,
    input  logic                 wb_reg_write_i,
    input  logic [REG_IDX_W-1:0] wb_write_addr_i,
    output logic [1:0]           fwd_sel_o
);

    localparam logic [REG_IDX_W-1:0] X0 = '0;

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    always_comb begin
        mem_hit   = (ex_rs_i != X0) && mem_reg_write_i && (mem_write_addr_i == ex_rs_i);
        wb_hit    = (ex_rs_i != X0) && wb_reg_write_i && (wb_write_addr_i == ex_rs_i);
        fwd_sel_o = fwd_select(mem_hit, wb_hit);
    end

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing controller: memory waits, taken branches, RAW stalls, counters.
// Build option HAZARD_FORWARD_EN adds operand forwarding and restricts stalls to load-use.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 32
) (
    input logic           clk,
    input logic           reset,
    hazard_ctrl_if.master hz
);

    localparam logic [REG_IDX_W-1:0] X0      = '0;
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       mem_wait;
    logic       load_use;
    logic       data_hazard;
    logic       branch_fire;
    hz_ctrl_t   ctrl;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic src_dep(
        logic                 wr,
        logic [REG_IDX_W-1:0] dst,
        logic                 uses1,
        logic [REG_IDX_W-1:0] rs1,
        logic                 uses2,
        logic [REG_IDX_W-1:0] rs2
    );
        return wr && (dst != X0) && ((uses1 && (rs1 == dst)) || (uses2 && (rs2 == dst)));
    endfunction

    always_comb begin
        load_use = src_dep(hz.exMemRead, hz.exWriteAddr, hz.idUsesRs1, hz.idRs1,
                           hz.idUsesRs2, hz.idRs2);
    end

`ifdef HAZARD_FORWARD_EN
    hazard_ctrl_forward_unit #(
        .REG_IDX_W (REG_IDX_W)
    ) u_fwd_a (
        .ex_rs_i          (hz.exRs1),
        .mem_reg_write_i  (hz.memRegWrite),
        .mem_write_addr_i (hz.memWriteAddr),
        .wb_reg_write_i   (hz.wbRegWrite),
        .wb_write_addr_i  (hz.wbWriteAddr),
        .fwd_sel_o        (fwd_a)
    );

    hazard_ctrl_forward_unit #(
        .REG_IDX_W (REG_IDX_W)
    ) u_fwd_b (
        .ex_rs_i          (hz.exRs2),
        .mem_reg_write_i  (hz.memRegWrite),
        .mem_write_addr_i (hz.memWriteAddr),
        .wb_reg_write_i   (hz.wbRegWrite),
        .wb_write_addr_i  (hz.wbWriteAddr),
        .fwd_sel_o        (fwd_b)
    );

    assign data_hazard = load_use;

    logic unused_ex_reg_write;
    assign unused_ex_reg_write = hz.exRegWrite;
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    // No bypass paths: any in-flight producer of an ID source holds ID until it retires.
    assign data_hazard = load_use
        || src_dep(hz.exRegWrite, hz.exWriteAddr, hz.idUsesRs1, hz.idRs1,
                   hz.idUsesRs2, hz.idRs2)
        || src_dep(hz.memRegWrite, hz.memWriteAddr, hz.idUsesRs1, hz.idRs1,
                   hz.idUsesRs2, hz.idRs2)
        || src_dep(hz.wbRegWrite, hz.wbWriteAddr, hz.idUsesRs1, hz.idRs1,
                   hz.idUsesRs2, hz.idRs2);

    logic unused_ex_rs;
    assign unused_ex_rs = ^{hz.exRs1, hz.exRs2};
`endif

    // Freeze only while memory is not ready: the cycle memReady rises is already a run cycle.
    always_comb begin
        mem_wait = !hz.memReady && ((state_q == HZ_MEM_WAIT) || hz.memReq);

        state_d = state_q;
        case (state_q)
            HZ_RUN: begin
                if (hz.memReq && !hz.memReady) begin
                    state_d = HZ_MEM_WAIT;
                end
            end
            HZ_MEM_WAIT: begin
                if (hz.memReady) begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_comb begin
        ctrl        = ctrl_run();
        branch_fire = 1'b0;
        if (reset) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
        end else if (mem_wait) begin
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_write  = 1'b0;
            ctrl.pipe_freeze = 1'b1;
        end else if (hz.exPCSrc) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            branch_fire     = 1'b1;
        end else if (data_hazard) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!reset && !ctrl.pc_write) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (branch_fire) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.PCWrite     = ctrl.pc_write;
    assign hz.IFIDWrite   = ctrl.ifid_write;
    assign hz.IFIDFlush   = ctrl.ifid_flush;
    assign hz.IDEXFlush   = ctrl.idex_flush;
    assign hz.pipeFreeze  = ctrl.pipe_freeze;
    assign hz.forwardA    = reset ? FWD_RF : fwd_a;
    assign hz.forwardB    = reset ? FWD_RF : fwd_b;
    assign hz.stallCycles = stall_cnt_q;
    assign hz.flushCount  = flush_cnt_q;

endmodule
